// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: LOAD mode fills the word store through an
// auto-incrementing pointer, RUN mode serves single-cycle-latency fetches.
//
// state  | meaning
// S_LOAD | program loading; load_we writes at the pointer, fetches ignored
// S_RUN  | fetch service; fetch_ready high, load_we ignored
module instr_mem_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              load_we,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ovf,
   output logic [ADDR_W:0]   word_count,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_adr,
   output logic              fetch_ready,
   output logic [DATA_W-1:0] instruction,
   output logic              instr_valid,
   output logic              fetch_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH-1);

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_written;
   logic [PTR_W-1:0]  r_ptr;
   logic              r_ovf;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_instr;
   logic              r_valid;
   logic              r_err;

   logic              w_wr;
   logic              w_enter_load;
   logic              w_accept;
   logic              w_oor;
   logic [PTR_W-1:0]  w_rd_idx;
   logic              w_hit;

   assign w_wr         = (r_state == S_LOAD) && load_we;
   assign w_enter_load = (r_state == S_RUN) && load_en;
   assign w_accept     = (r_state == S_RUN) && fetch_req;
   assign w_oor        = {1'b0, fetch_adr} >= DEPTH_CNT;
   assign w_rd_idx     = fetch_adr[PTR_W-1:0];
   // Out-of-range addresses never reach the written lookup result
   assign w_hit        = !w_oor && r_written[w_rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD:  if (!load_en) w_state_nxt = S_RUN;
         S_RUN:   if (load_en)  w_state_nxt = S_LOAD;
         default: w_state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_ovf     <= 1'b0;
         r_written <= '0;
         r_count   <= '0;
      end else if (w_enter_load) begin
         r_ptr <= '0;
         r_ovf <= 1'b0;
      end else if (w_wr) begin
         r_written[r_ptr] <= 1'b1;
         if (!r_written[r_ptr] && (r_count != DEPTH_CNT)) begin
            r_count <= r_count + (ADDR_W+1)'(1);
         end
         if (r_ptr == PTR_LAST) begin
            r_ptr <= '0;
            r_ovf <= 1'b1;
         end else begin
            r_ptr <= r_ptr + PTR_W'(1);
         end
      end
   end

   // Storage carries no reset; r_written alone says which words are valid
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_ptr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_accept;
         r_err   <= w_accept && !w_hit;
         if (w_accept) begin
            r_instr <= w_hit ? r_mem[w_rd_idx] : '0;
         end
      end
   end

   assign fetch_ready = (r_state == S_RUN);
   assign load_ovf    = r_ovf;
   assign word_count  = r_count;
   assign instruction = r_instr;
   assign instr_valid = r_valid;
   assign fetch_err   = r_err;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed and randomized checks of instr_mem_ctrl against a behavioural
// model of the load/fetch rules (DEPTH=32 with a 6-bit fetch address).
module tb_instr_mem_ctrl;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load_en;
   logic              load_we;
   logic [DATA_W-1:0] load_data;
   logic              load_ovf;
   logic [ADDR_W:0]   word_count;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_adr;
   logic              fetch_ready;
   logic [DATA_W-1:0] instruction;
   logic              instr_valid;
   logic              fetch_err;

   instr_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (load_en),
      .load_we     (load_we),
      .load_data   (load_data),
      .load_ovf    (load_ovf),
      .word_count  (word_count),
      .fetch_req   (fetch_req),
      .fetch_adr   (fetch_adr),
      .fetch_ready (fetch_ready),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   bit              m_run;
   int              m_ptr;
   int              m_cnt;
   bit              m_ovf;
   bit              m_iv;
   bit              m_err;
   logic [DATA_W-1:0] m_instr;
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit              m_wr  [DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ready"}, 32'(fetch_ready), 32'(m_run));
      chk({tag, ".valid"}, 32'(instr_valid), 32'(m_iv));
      chk({tag, ".err"},   32'(fetch_err),   32'(m_err));
      chk({tag, ".instr"}, 32'(instruction), 32'(m_instr));
      chk({tag, ".ovf"},   32'(load_ovf),    32'(m_ovf));
      chk({tag, ".count"}, 32'(word_count),  32'(m_cnt));
   endtask

   // Apply the spec rules to the inputs present before the edge, then compare
   task automatic tick(input string tag);
      bit acc;
      int a;
      acc = m_run && fetch_req;
      a   = int'(fetch_adr);
      m_iv  = acc;
      m_err = 1'b0;
      if (acc) begin
         if (a >= DEPTH) begin
            m_instr = '0;
            m_err   = 1'b1;
         end else if (!m_wr[a]) begin
            m_instr = '0;
            m_err   = 1'b1;
         end else begin
            m_instr = m_mem[a];
         end
      end
      if (!m_run && load_we) begin
         if (!m_wr[m_ptr] && m_cnt < DEPTH) m_cnt++;
         m_mem[m_ptr] = load_data;
         m_wr[m_ptr]  = 1'b1;
         m_ptr = (m_ptr + 1) % DEPTH;
         if (m_ptr == 0) m_ovf = 1'b1;
      end
      if (!m_run && !load_en) begin
         m_run = 1'b1;
      end else if (m_run && load_en) begin
         m_run = 1'b0;
         m_ptr = 0;
         m_ovf = 1'b0;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #2;
      m_run = 1'b0; m_ptr = 0; m_cnt = 0; m_ovf = 1'b0;
      m_iv = 1'b0; m_err = 1'b0; m_instr = '0;
      for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle_inputs();
      load_we = 1'b0; fetch_req = 1'b0; load_data = '0; fetch_adr = '0;
   endtask

   initial begin
      logic [DATA_W-1:0] prog [3];
      logic [DATA_W-1:0] last_val;
      prog[0] = 16'h0841; prog[1] = 16'h5300; prog[2] = 16'h6300;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      load_en = 1'b1;
      idle_inputs();
      do_reset("rst0");

      // three-word program written from the first edge after reset release
      for (int i = 0; i < 3; i++) begin
         load_we = 1'b1; load_data = prog[i];
         tick($sformatf("load%0d", i));
      end
      // fetch offered while still in LOAD is dropped
      load_we = 1'b0; load_en = 1'b0; fetch_req = 1'b1; fetch_adr = 6'd0;
      tick("to_run");
      chk("ignored_fetch", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         fetch_adr = ADDR_W'(i);
         tick($sformatf("fetch%0d", i));
         chk($sformatf("prog_data%0d", i), 32'(instruction), 32'(prog[i]));
         chk($sformatf("prog_err%0d", i), 32'(fetch_err), 32'd0);
      end
      chk("prog_count", 32'(word_count), 32'd3);
      fetch_req = 1'b0;
      tick("hold");
      chk("hold_instr", 32'(instruction), 32'h6300);

      fetch_req = 1'b1; fetch_adr = 6'd7;
      tick("unwritten");
      chk("unwritten_err", 32'(fetch_err), 32'd1);
      fetch_adr = 6'd40;
      tick("oor");
      chk("oor_err", 32'(fetch_err), 32'd1);
      chk("oor_instr", 32'(instruction), 32'd0);

      // writes in RUN must not land
      fetch_req = 1'b0; load_we = 1'b1; load_data = 16'hFFFF;
      tick("run_we");
      load_we = 1'b0; fetch_req = 1'b1; fetch_adr = 6'd0;
      tick("run_we_fetch");
      chk("run_we_data", 32'(instruction), 32'h0841);

      // fetch accepted on the cycle load_en rises still completes
      fetch_adr = 6'd1; load_en = 1'b1;
      tick("fetch_on_load");
      chk("fol_valid", 32'(instr_valid), 32'd1);
      chk("fol_data", 32'(instruction), 32'h5300);
      chk("fol_ready", 32'(fetch_ready), 32'd0);
      tick("fol_after");

      // 33 writes wrap the pointer; 33rd value lands in word 0
      fetch_req = 1'b0; load_we = 1'b1;
      last_val = '0;
      for (int i = 0; i < 33; i++) begin
         load_data = DATA_W'($urandom);
         last_val  = load_data;
         tick($sformatf("wrap%0d", i));
         if (i == 30) chk("ovf_before_wrap", 32'(load_ovf), 32'd0);
         if (i == 31) chk("ovf_at_wrap", 32'(load_ovf), 32'd1);
      end
      load_we = 1'b0; load_en = 1'b0;
      tick("wrap_run");
      fetch_req = 1'b1; fetch_adr = 6'd0;
      tick("wrap_fetch");
      chk("wrap_word0", 32'(instruction), 32'(last_val));
      chk("wrap_count", 32'(word_count), 32'd32);
      chk("wrap_ovf_kept", 32'(load_ovf), 32'd1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (m_run) load_en = ($urandom_range(0, 9) == 0);
         else       load_en = ($urandom_range(0, 3) != 0);
         load_we   = 1'($urandom);
         load_data = DATA_W'($urandom);
         fetch_req = 1'($urandom);
         fetch_adr = ADDR_W'($urandom_range(0, 40));
         tick($sformatf("rnd%0d", i));
      end

      // reset in the middle of a load burst
      idle_inputs(); load_en = 1'b1;
      tick("pre_burst");
      load_we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         load_data = DATA_W'($urandom);
         tick($sformatf("burst%0d", i));
      end
      load_we = 1'b0;
      do_reset("rst_mid");
      chk("rst_mid_count", 32'(word_count), 32'd0);
      load_en = 1'b0;
      tick("post_rst_run");
      fetch_req = 1'b1; fetch_adr = 6'd2;
      tick("post_rst_fetch2");
      chk("post_rst_err", 32'(fetch_err), 32'd1);
      chk("post_rst_instr", 32'(instruction), 32'd0);
      fetch_adr = 6'd0;
      tick("post_rst_fetch0");
      fetch_req = 1'b0;
      tick("end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5: fetch address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 32: number of stored words; legal range 2 to 2**ADDR_W.
REQ-004 The block SHALL have a single clock and an asynchronous, active-low reset, listed first as ports clk and rst_n.
REQ-005 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-006 Port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-007 Port load_en, input, 1 bit: level; high requests LOAD mode.
REQ-008 Port load_we, input, 1 bit: writes load_data at the load pointer while in LOAD.
REQ-009 Port load_data, input, DATA_W bits: program word to store.
REQ-010 Port load_ovf, output, 1 bit: sticky flag; load pointer wrapped during the current LOAD session.
REQ-011 Port word_count, output, ADDR_W+1 bits: distinct words written since reset; saturates at DEPTH.
REQ-012 Port fetch_req, input, 1 bit: fetch request; accepted when fetch_req and fetch_ready are both high.
REQ-013 Port fetch_adr, input, ADDR_W bits: fetch address.
REQ-014 Port fetch_ready, output, 1 bit: high only in RUN.
REQ-015 Port instruction, output, DATA_W bits: registered fetch result.
REQ-016 Port instr_valid, output, 1 bit: one-cycle pulse qualifying instruction.
REQ-017 Port fetch_err, output, 1 bit: pulse with instr_valid; address out of range or word never written.

Function
REQ-018 The block SHALL have a two-state FSM: LOAD (entered on reset) and RUN.
REQ-019 In LOAD, load_en low SHALL move the FSM to RUN on the next edge; fetch_ready SHALL rise in that same cycle.
REQ-020 In RUN, load_en high SHALL move the FSM to LOAD on the next edge, with any fetch accepted in the same cycle still completing.
REQ-021 Entry to LOAD SHALL clear the load pointer to 0 and clear load_ovf.
REQ-022 In LOAD, load_we high SHALL write load_data to mem[ptr], set written[ptr], and increment ptr.
REQ-023 With ptr equal to DEPTH-1, a write SHALL wrap ptr to 0 and set load_ovf, which stays high until the next entry to LOAD.
REQ-024 word_count SHALL increment only on a write to a word whose written bit was clear, and SHALL hold at DEPTH.
REQ-025 load_we in RUN SHALL be ignored: no write, no pointer change.
REQ-026 An accepted fetch SHALL produce instr_valid high and instruction valid exactly one cycle later (latency 1); one fetch can be accepted per cycle, giving full throughput.
REQ-027 A fetch with fetch_adr >= DEPTH, or to a word with written clear, SHALL return instruction = 0 (the NOP encoding) with fetch_err high.
REQ-028 Without an accepted fetch, instr_valid and fetch_err SHALL be 0 and instruction SHALL hold its last value.
REQ-029 fetch_req while fetch_ready is low SHALL be ignored, with no queuing.
REQ-030 Memory contents SHALL NOT be reset; the written bits SHALL be the only record of which words are valid.

Reset
REQ-031 Assertion of rst_n low SHALL immediately force: FSM = LOAD, ptr = 0, all written bits = 0, word_count = 0, load_ovf = 0, fetch_ready = 0, instr_valid = 0, fetch_err = 0, instruction = 0.
REQ-032 Reset during a LOAD burst SHALL discard all valid marks; a following fetch of any address SHALL return 0 with fetch_err, until reloaded.
REQ-033 Deassertion of rst_n SHALL be synchronous to clk; the first write SHALL be accepted on the first clock edge after deassertion.

Verification
REQ-034 Reset, load_en=1, write 0x0841, 0x5300, 0x6300 over 3 cycles, load_en=0, fetch addresses 0, 1, 2 back-to-back -> instr_valid for 3 consecutive cycles, each 1 cycle after its request, data 0x0841, 0x5300, 0x6300, fetch_err=0, word_count=3.
REQ-035 Load 3 words, then fetch address 7 -> instruction=0x0000, fetch_err=1; fetch address 40 with ADDR_W=6, DEPTH=32 -> instruction=0, fetch_err=1.
REQ-036 Write 33 words with DEPTH=32 -> load_ovf=1 after the 32nd write, word 0 holds the 33rd value, word_count=32.
REQ-037 In RUN, load_we=1 with data 0xFFFF -> memory unchanged; fetch of address 0 returns its prior value.
REQ-038 Fetch accepted in the same cycle load_en rises -> instr_valid next cycle with correct data, then fetch_ready=0.
REQ-039 rst_n pulsed low mid-load after 5 words -> all outputs 0 immediately; after reload of 0 words and load_en=0, fetch address 2 -> fetch_err=1.
